dcache_responder: RTL and testbench
===================================

# dcache_responder

Direct-mapped, write-back, write-allocate data cache. It is the responder to the core's `read`/`write`/`ready` cache request interface and the initiator toward byte-lane data memory (`mem_addr`, `mem_data_in[0:3]`, `mem_write_en`, `mem_data_out[0:3]`). It sits between `mips_core` and the memory model. It serves hits in zero stall cycles and stalls the core through `ready` on misses.

## Interface
- `NUM_LINES`, 8: number of one-word lines; power of two, at least 2.
- `MEM_LATENCY`, 4: cycles from `mem_addr` being stable until `mem_data_out` is valid; at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `read` in 1: load request.
- `write` in 1: store request.
- `load_address` in 32: load word address; bits [1:0] ignored.
- `write_address` in 32: store word address; bits [1:0] ignored.
- `write_data` in 32: store data (full word).
- `load_data` out 32: registered load result.
- `hit` out 1: combinational; the current request hits.
- `ready` out 1: cache idle; a request is accepted at the next edge.
- `mem_addr` out 32: memory word address.
- `mem_data_in` out 8 x [0:3]: write bytes; [0] = bits 31:24 (big-endian).
- `mem_write_en` out 1: memory commits `mem_data_in` at `mem_addr` on this edge.
- `mem_data_out` in 8 x [0:3]: read bytes; [0] = bits 31:24.

## Operation
- Address split: index = addr[2+IB-1:2] with IB = log2(NUM_LINES); tag = addr[31:2+IB].
- Per-line state: valid, dirty, tag, 32-bit data.
- Request selection: if `write` is high, it wins and `read` is ignored. The active address is `write_address` for stores and `load_address` for loads.
- `ready` = (state == IDLE). Requests seen while `ready`=0 are ignored. The core holds its request until `ready` returns.
- `hit` = IDLE & (read|write) & valid[idx] & tag match. It is 0 in every other state.
- States:
  - IDLE:
    - Read hit: `load_data` <= line data; stay in IDLE.
    - Write hit: data <= `write_data`, dirty <= 1; stay in IDLE.
    - Miss with a clean or invalid victim: a read goes to FILL; a write installs {valid=1, dirty=1, tag, `write_data`} and stays in IDLE (no fill, because the store is a full word).
    - Miss with a valid and dirty victim: latch the request and go to WB.
  - WB (exactly 1 cycle): `mem_addr` = {victim tag, idx, 2'b00}; `mem_data_in` = victim data; `mem_write_en`=1.
    - Next state is FILL for a latched read.
    - For a latched write, install the store line (dirty=1) and go to IDLE.
  - FILL (MEM_LATENCY cycles): `mem_addr` = latched address with [1:0]=0; counter runs 0..MEM_LATENCY-1.
    - At the edge where the counter equals MEM_LATENCY-1: line <= {valid=1, dirty=0, tag, `mem_data_out` packed}; `load_data` <= the same word; go to IDLE.
- Memory outputs outside WB and FILL: `mem_addr`=0, `mem_data_in`=0, `mem_write_en`=0.
- No memory write happens except in WB. Clean evictions are silent.

## Timing
- Reset values: `load_data`=0, `ready`=1, `hit`=0, `mem_addr`=0, `mem_data_in`={0,0,0,0}, `mem_write_en`=0. All lines are invalid and clean, state is IDLE, and the counter is 0.
- Read hit: accepted at edge E0; `load_data` is valid after E0; `ready` never drops.
- Clean read miss: `ready` is low for MEM_LATENCY cycles after E0 and high again after edge E0+MEM_LATENCY, with `load_data` valid.
- Dirty read miss: `ready` is low for MEM_LATENCY+1 cycles; `mem_write_en` is high for exactly the first of them.
- Write miss: 0 stall cycles if the victim is clean; 1 stall cycle if it is dirty.
- `load_data` holds its value until the next completed load.
- Reset asserted in WB or FILL aborts the access. `mem_write_en` is 0 in the cycle after reset, and dirty contents are discarded.
- Reset has priority over any request at the same edge.

## Structure
- Package `dcache_pkg` holds:
  - state enum {IDLE, WB, FILL};
  - helper functions for index, tag and offset widths;
  - big-endian pack and unpack functions (byte array to word and back).
- One sub-module, `dcache_line_store`: valid/dirty/tag/data arrays with one read port (combinational) and one write port. It is cleared by `rst`.
- FSM, counter and request latch live in `dcache_responder`.

## Test plan
All scenarios use NUM_LINES=8 and MEM_LATENCY=4.
- **Cold read miss.** After reset, memory word 0x40 = 0x11223344; read 0x40.
  - Response: `hit`=0; `ready` low for 4 cycles; `mem_addr`=0x40 in FILL; then `load_data`=0x11223344.
  - Repeating the read gives `hit`=1 with `ready` staying 1.
- **Write hit.** Write 0xDEADBEEF to 0x40.
  - Response: `hit`=1; no `mem_write_en`; a following read of 0x40 returns 0xDEADBEEF with 0 stalls.
- **Dirty eviction.** Read 0x60 (same index 0, tag 3).
  - Response: one cycle of `mem_write_en`=1 with `mem_addr`=0x40 and `mem_data_in`={DE,AD,BE,EF}.
  - Then FILL from 0x60; `ready` low for 5 cycles in total.
- **Clean write miss.** Write 0xCAFEF00D to 0x84.
  - Response: `ready` stays 1; no memory traffic.
  - A read of 0x84 hits and returns 0xCAFEF00D.
- **Simultaneous read and write.** `read`=`write`=1, `load_address`=0x84, `write_address`=0x88, `write_data`=0x5.
  - Response: only the store is performed; line 0x88 holds 0x5; `load_data` is unchanged.
- **Reset mid-FILL.** Assert `rst` during cycle 2 of a FILL.
  - Response: next cycle `ready`=1 and `mem_write_en`=0.
  - A read of 0x40 then misses (`hit`=0).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM encodings, address-field
// widths and big-endian byte-lane packing.
package dcache_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWb   = 2'd1;
    localparam logic [1:0] StFill = 2'd2;

    typedef logic [7:0] be_bytes_t [0:3];

    function automatic int unsigned offset_bits();
        return 2;
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned num_lines);
        return 32 - offset_bits() - $clog2(num_lines);
    endfunction

    // Lane 0 carries bits 31:24.
    function automatic logic [31:0] be_pack(input be_bytes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic [7:0] be_unpack(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] res;
        case (lane)
            2'd0:    res = w[31:24];
            2'd1:    res = w[23:16];
            2'd2:    res = w[15:8];
            default: res = w[7:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage: one combinational read port, one write port.
// Reset invalidates and cleans every line; tag and data are left as they are.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_BITS  = idx_bits(NUM_LINES),
    parameter int unsigned TAG_BITS  = tag_bits(NUM_LINES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_dirty,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache between the core request
// interface and byte-lane memory. Hits complete without stalling; misses hold ready low.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES   = 8,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] load_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        hit,
    output logic        ready,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_out [0:3]
);

    localparam int unsigned OB = offset_bits();
    localparam int unsigned IB = idx_bits(NUM_LINES);
    localparam int unsigned TB = tag_bits(NUM_LINES);
    localparam int unsigned CW = $clog2(MEM_LATENCY) + 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lat_write_q, lat_write_d;
    logic [31:0]   lat_addr_q, lat_addr_d;
    logic [31:0]   lat_data_q, lat_data_d;
    logic [31:0]   load_data_d;

    logic [31:0]   req_addr;
    logic [IB-1:0] req_idx, lat_idx, rd_idx, wr_idx;
    logic [TB-1:0] req_tag, lat_tag, rd_tag, wr_tag;
    logic          rd_valid, rd_dirty, wr_en, wr_dirty;
    logic [31:0]   rd_data, wr_data, fill_word;

    assign req_addr  = write ? write_address : load_address;
    assign req_idx   = req_addr[OB +: IB];
    assign req_tag   = req_addr[OB+IB +: TB];
    assign lat_idx   = lat_addr_q[OB +: IB];
    assign lat_tag   = lat_addr_q[OB+IB +: TB];
    assign fill_word = be_pack(mem_data_out);

    assign ready  = (state_q == StIdle);
    // Outside IDLE the port looks at the latched line, i.e. the victim during WB.
    assign rd_idx = ready ? req_idx : lat_idx;
    assign hit    = ready & (read | write) & rd_valid & (rd_tag == req_tag);

    dcache_line_store #(
        .NUM_LINES (NUM_LINES)
    ) u_line_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        load_data_d  = load_data;
        wr_en        = 1'b0;
        wr_idx       = req_idx;
        wr_dirty     = 1'b1;
        wr_tag       = req_tag;
        wr_data      = write_data;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_data_in  = '{default: 8'h00};

        case (state_q)
            StIdle: begin
                if (read | write) begin
                    lat_write_d = write;
                    lat_addr_d  = req_addr;
                    lat_data_d  = write_data;
                    if (hit) begin
                        if (write) wr_en = 1'b1;
                        else       load_data_d = rd_data;
                    end else if (rd_valid & rd_dirty) begin
                        state_d = StWb;
                    end else if (write) begin
                        // Full-word store: allocate without fetching the old word.
                        wr_en = 1'b1;
                    end else begin
                        state_d = StFill;
                        cnt_d   = '0;
                    end
                end
            end
            StWb: begin
                mem_addr     = {rd_tag, lat_idx, 2'b00};
                mem_write_en = 1'b1;
                for (int i = 0; i < 4; i++) mem_data_in[i] = be_unpack(rd_data, 2'(i));
                if (lat_write_q) begin
                    wr_en   = 1'b1;
                    wr_idx  = lat_idx;
                    wr_tag  = lat_tag;
                    wr_data = lat_data_q;
                    state_d = StIdle;
                end else begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                mem_addr = lat_addr_q & ~32'h3;
                if (cnt_q == CW'(MEM_LATENCY - 1)) begin
                    wr_en       = 1'b1;
                    wr_idx      = lat_idx;
                    wr_dirty    = 1'b0;
                    wr_tag      = lat_tag;
                    wr_data     = fill_word;
                    load_data_d = fill_word;
                    state_d     = StIdle;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            load_data   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_addr_q  <= lat_addr_d;
            lat_data_q  <= lat_data_d;
            load_data   <= load_data_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: a line-level cache model predicts hits, stalls,
// load results and write-backs; monitors compare them against the DUT as they appear.
module tb_dcache_responder;

    localparam int unsigned NL  = 8;
    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] load_address = '0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] load_data;
    logic        hit;
    logic        ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];

    always #5 clk = ~clk;

    dcache_responder #(
        .NUM_LINES   (NL),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read          (read),
        .write         (write),
        .load_address  (load_address),
        .write_address (write_address),
        .write_data    (write_data),
        .load_data     (load_data),
        .hit           (hit),
        .ready         (ready),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_write_en  (mem_write_en),
        .mem_data_out  (mem_data_out)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        bit          is_read;
        bit          hit;
        logic [31:0] load;
        int          stall;
        logic [31:0] fill_addr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_t;

    exp_t exp_q[$];
    wb_t  wb_q[$];

    // Memory seen by the DUT and the model's own copy, keyed by word number.
    logic [31:0] phys    [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a >> 2) ? phys[a >> 2] : init_word(a & ~32'h3);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a & ~32'h3);
    endfunction

    always @(negedge clk) begin
        logic [31:0] w;
        wb_t         e;
        if (mem_write_en) begin
            w = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
            if (wb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wb: write of 0x%08h at 0x%08h, expected none", w,
                         mem_addr);
            end else begin
                e = wb_q.pop_front();
                chk("wb_addr", mem_addr, e.addr);
                chk("wb_data", w, e.data);
            end
            phys[mem_addr >> 2] = w;
        end
        w = phys_rd(mem_addr);
        for (int i = 0; i < 4; i++) mem_data_out[i] = w[31-8*i -: 8];
    end

    // Cache model: each line remembers which word it holds.
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [31:0] m_word  [NL];
    logic [31:0] m_data  [NL];
    logic [31:0] last_load = '0;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        last_load = '0;
    endtask

    task automatic model(input bit wr, input logic [31:0] la, input logic [31:0] wa,
                         input logic [31:0] wd, output exp_t e);
        logic [31:0] addr;
        int          idx;
        wb_t         w;
        addr        = (wr ? wa : la) & ~32'h3;
        idx         = int'((addr >> 2) % NL);
        e.is_read   = !wr;
        e.hit       = m_valid[idx] && (m_word[idx] == addr);
        e.fill_addr = addr;
        e.stall     = 0;
        if (!e.hit && m_valid[idx] && m_dirty[idx]) begin
            w.addr = m_word[idx];
            w.data = m_data[idx];
            wb_q.push_back(w);
            ref_mem[m_word[idx] >> 2] = m_data[idx];
            e.stall = 1;
        end
        if (wr) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b1;
            m_word[idx]  = addr;
            m_data[idx]  = wd;
        end else begin
            if (!e.hit) begin
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
                m_word[idx]  = addr;
                m_data[idx]  = ref_rd(addr);
                e.stall      = e.stall + LAT;
            end
            last_load = m_data[idx];
        end
        e.load = last_load;
    endtask

    bit   pend = 1'b0;
    int   stall_cnt = 0;
    exp_t cur;

    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (!ready) begin
                    stall_cnt++;
                    if (cur.is_read && !mem_write_en) chk("fill_addr", mem_addr, cur.fill_addr);
                end else begin
                    pend = 1'b0;
                    chk("stall_cycles", stall_cnt, cur.stall);
                    chk("load_data", load_data, cur.load);
                end
            end
            if (!pend && ready && (read || write)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL no_expectation: request seen, expected none");
                end else begin
                    cur = exp_q.pop_front();
                    chk("hit", hit, cur.hit);
                    pend      = 1'b1;
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] la,
                         input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            $display("FAIL ready_timeout: ready 0, expected 1 within 20 cycles");
        end else begin
            model(wr, la, wa, wd, e);
            exp_q.push_back(e);
            read          = rd;
            write         = wr;
            load_address  = la;
            write_address = wa;
            write_data    = wd;
            @(posedge clk);
            #1;
            read  = 1'b0;
            write = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        logic [31:0] la, wa;
        phys[32'h40 >> 2]    = 32'h11223344;
        ref_mem[32'h40 >> 2] = 32'h11223344;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_ready", ready, 1);
        chk("rst_hit", hit, 0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_mem_data_in",
            {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}, 32'h0);
        rst = 1'b0;

        issue(1, 0, 32'h40, 0, 0);                       // cold miss
        issue(1, 0, 32'h40, 0, 0);                       // hit
        issue(0, 1, 0, 32'h40, 32'hDEADBEEF);            // write hit
        issue(1, 0, 32'h40, 0, 0);
        issue(1, 0, 32'h60, 0, 0);                       // dirty eviction
        issue(0, 1, 0, 32'h84, 32'hCAFEF00D);            // clean write miss
        issue(1, 0, 32'h84, 0, 0);
        issue(1, 1, 32'h84, 32'h88, 32'h5);              // store wins
        issue(1, 0, 32'h88, 0, 0);

        // Reset during the second FILL cycle.
        issue(1, 0, 32'h40, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_mem_we", mem_write_en, 0);
        chk("abort_load_data", load_data, 32'h0);
        model_reset();
        rst = 1'b0;
        issue(1, 0, 32'h40, 0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 2));
            la   = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            wa   = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            issue(kind != 1, kind != 0, la, wa, $urandom);
        end

        repeat (LAT + 4) @(negedge clk);
        chk("pending_done", pend, 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
